dot_matrix_frame_ctrl: RTL
==========================

Name: dot_matrix_frame_ctrl

Overview:
Frame-level controller for the 8x8 LED dot matrix. Holds two 8x8 bit banks: one front bank that is displayed and one back bank that receives writes. It scans the front bank row by row with a programmable per-row dwell and a dead-time blank between rows. Bank swaps are requested by a producer (keypad/pattern logic) and are granted only at frame boundaries, so the display never tears. It sits between pattern-generating logic and the matrix row/column pins.

Parameters:
DWELL, 4, clock cycles each row is held; legal range 2..255.
DEAD, 1, leading cycles of each row dwell with columns forced off (anti-ghosting); legal range 0..DWELL-1.

Ports:
clock  input  1  system clock; all logic is on the rising edge.
reset  input  1  synchronous, active-low reset.
wr_en  input  1  write strobe into the back bank.
wr_row  input  3  back-bank row address.
wr_data  input  8  row data; bit7 is the leftmost column, 1 = LED on.
swap_req  input  1  request to exchange front and back banks.
blank  input  1  forces the display dark; scan keeps running.
swap_ack  output  1  one-cycle pulse when a swap takes effect.
frame_done  output  1  one-cycle pulse at the end of every frame.
dot_row  output  8  active-low one-hot row select.
dot_col  output  8  active-high column data.

Behaviour:
- Reset (reset=0 at a clock edge) clears:
  - row_idx=0, dwell_cnt=0, bank_sel=0, swap_pending=0.
  - Both banks to all zeros.
  - dot_row=8'hFF, dot_col=8'h00, swap_ack=0, frame_done=0.
- Reset mid-frame has the same effect; no partial state survives.
- Scan counters:
  - dwell_cnt counts 0..DWELL-1, then returns to 0 and row_idx increments.
  - row_idx wraps from 7 to 0.
  - Frame period is 8*DWELL cycles.
- frame_end = (row_idx==7 && dwell_cnt==DWELL-1).
- Outputs are registered with 1 cycle latency from the (row_idx, dwell_cnt) state:
  - dot_row clears bit (7-row_idx) and sets all other bits. Row 0 gives 8'b01111111; row 7 gives 8'b11111110.
  - dot_col = 8'h00 if dwell_cnt<DEAD, otherwise front[row_idx].
  - If blank=1: dot_row=8'hFF and dot_col=8'h00 on the next edge. Counters, writes and swaps are unaffected.
- After reset is released, the first edge outputs the row 0 / dwell 0 state.
- Writes:
  - When wr_en=1, back[wr_row] <= wr_data on the edge.
  - The front bank is never writable.
  - Write and read of the same bank never collide, because the front bank is only read.
- Swap handshake:
  - swap_req=1 in any cycle sets swap_pending.
  - On a frame_end cycle with (swap_pending | swap_req):
    - bank_sel toggles.
    - swap_pending clears.
    - swap_ack=1 on the following cycle, for exactly 1 cycle.
  - Multiple requests within one frame produce a single swap and a single ack.
  - A swap_req asserted on the same cycle as frame_end is serviced at that boundary.
  - A swap_req on the cycle after frame_end waits for the next boundary.
- frame_done: 1 for exactly 1 cycle, on the cycle after every frame_end, regardless of blank or swap.
- Write on a swap cycle: the write targets the pre-swap back bank, which becomes the new front bank. The data is therefore visible in the very next frame.
- After a swap, the new back bank holds the old front contents. There is no implicit clear.
- Arithmetic: dwell_cnt width is clog2(DWELL); row_idx is 3 bits; wrap-around is exact, with no skipped or repeated row.

Test Plan:
1. Reset scan sequence (DWELL=4, DEAD=1).
   - Stimulus: hold reset=0 for 3 cycles, then release.
   - Required: dot_row=8'hFF and dot_col=8'h00 during reset.
   - Then dot_row=8'h7F for 4 cycles, 8'hBF for 4 cycles, ..., 8'hFE, wrapping back to 8'h7F 32 cycles after the first 7F.
   - frame_done pulses on cycle 33, then every 32 cycles.
2. Basic swap.
   - Stimulus: write row2=8'hA5 with no swap.
   - Required: dot_col stays 8'h00 for the whole frame.
   - Stimulus: pulse swap_req once mid-frame.
   - Required: swap_ack fires with frame_done. In the next frame, the row-2 dwell (dot_row=8'hDF) shows dot_col=8'h00 for 1 cycle, then 8'hA5 for 3 cycles. All other rows show 8'h00.
3. Request coalescing.
   - Stimulus: swap_req in 3 separate cycles within one frame.
   - Required: exactly one swap_ack, one bank_sel toggle, and no ack in the following frame.
4. Boundary timing.
   - Stimulus A: swap_req on the frame_end cycle. Required: swap at that boundary.
   - Stimulus B: swap_req one cycle later. Required: swap_ack is delayed by 32 cycles.
   - Stimulus C: wr_en row5=8'h3C on the swap cycle. Required: 8'h3C is displayed on row 5 in the next frame.
5. Blanking.
   - Stimulus: blank=1 for 40 cycles with a non-zero front bank.
   - Required: dot_row=8'hFF and dot_col=8'h00 throughout; frame_done still pulses; on release, the scan resumes at the correct row phase.
6. Reset mid-frame.
   - Stimulus: fill both banks, then assert reset at row 4.
   - Required: all outputs go to their reset values on the next edge; after release, every row shows 8'h00; swap_pending is cleared (no spurious swap_ack).

Source files
------------

// File: rtl/dot_matrix_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dot_matrix_frame_ctrl
// Brief    : Double-buffered 8x8 LED matrix scanner with tear-free bank swap.
// Revision : 1.0 - initial release
// ============================================================================
module dot_matrix_frame_ctrl #(
    parameter int DWELL = 4,
    parameter int DEAD  = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [2:0] wr_row,
    input  logic [7:0] wr_data,
    input  logic       swap_req,
    input  logic       blank,
    output logic       swap_ack,
    output logic       frame_done,
    output logic [7:0] dot_row,
    output logic [7:0] dot_col
);

    localparam int                 c_CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(DWELL - 1);

    logic [2:0]         r_row_idx;
    logic [c_CNT_W-1:0] r_dwell_cnt;
    logic               r_bank_sel;
    logic               r_swap_pending;
    logic [7:0]         r_bank0 [8];
    logic [7:0]         r_bank1 [8];

    logic       w_frame_end;
    logic       w_do_swap;
    logic       w_in_dead;
    logic [7:0] w_front_row;
    logic [7:0] w_row_sel;

    always_comb begin
        w_frame_end = (r_row_idx == 3'd7) && (r_dwell_cnt == c_LAST);
        w_do_swap   = w_frame_end && (r_swap_pending || swap_req);
        w_in_dead   = int'(r_dwell_cnt) < DEAD;
        w_front_row = r_bank_sel ? r_bank1[r_row_idx] : r_bank0[r_row_idx];
        w_row_sel   = ~(8'h80 >> r_row_idx);
    end

    // Scan counters, bank select and swap handshake
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_row_idx      <= 3'd0;
            r_dwell_cnt    <= '0;
            r_bank_sel     <= 1'b0;
            r_swap_pending <= 1'b0;
            swap_ack       <= 1'b0;
            frame_done     <= 1'b0;
        end else begin
            if (r_dwell_cnt == c_LAST) begin
                r_dwell_cnt <= '0;
                r_row_idx   <= r_row_idx + 3'd1;
            end else begin
                r_dwell_cnt <= r_dwell_cnt + 1'b1;
            end
            if (w_do_swap) begin
                r_bank_sel     <= ~r_bank_sel;
                r_swap_pending <= 1'b0;
            end else if (swap_req) begin
                r_swap_pending <= 1'b1;
            end
            swap_ack   <= w_do_swap;
            frame_done <= w_frame_end;
        end
    end

    // Writes always land in the current back bank, even on the swap edge,
    // so that data becomes front content for the very next frame.
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < 8; i++) begin
                r_bank0[i] <= 8'h00;
                r_bank1[i] <= 8'h00;
            end
        end else if (wr_en) begin
            if (r_bank_sel) begin
                r_bank0[wr_row] <= wr_data;
            end else begin
                r_bank1[wr_row] <= wr_data;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset || blank) begin
            dot_row <= 8'hFF;
            dot_col <= 8'h00;
        end else begin
            dot_row <= w_row_sel;
            dot_col <= w_in_dead ? 8'h00 : w_front_row;
        end
    end

endmodule
`default_nettype wire
